score_display: RTL and testbench

- Downstream consumer of the collision detector's score, lives and game_over outputs.
- Converts the 16-bit binary score to five BCD digits with an iterative double-dabble FSM.
- Drives five active-low 7-segment displays with leading-zero blanking, plus a lives thermometer on LEDs.
- Blinks the score display while game_over is high. Runs on the system clock; frame timing comes from a 60 Hz enable pulse.

---
 rtl/score_display.sv | 188 ++++++++++++++++++
 tb/tb_score_display.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/score_display.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : score_display
//  Description : Binary score to five-digit 7-segment display (double dabble),
//                lives thermometer LEDs and game-over blink.
//  Revision    : 1.0 - initial release
// ============================================================================
module score_display #(
    parameter int SCORE_W     = 16,
    parameter int DIGITS      = 5,
    parameter int BLINK_TICKS = 30
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               frame_tick,
    input  logic [SCORE_W-1:0] score,
    input  logic [1:0]         lives,
    input  logic               game_over,
    output logic [6:0]         hex0,
    output logic [6:0]         hex1,
    output logic [6:0]         hex2,
    output logic [6:0]         hex3,
    output logic [6:0]         hex4,
    output logic [2:0]         lives_led,
    output logic               busy
);

    localparam int c_bcd_w = 4 * DIGITS;
    localparam int c_cnt_w = $clog2(SCORE_W + 1);
    localparam int c_blk_w = $clog2(BLINK_TICKS + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LOAD  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [SCORE_W-1:0]   shreg_q, shreg_d;
    logic [SCORE_W-1:0]   last_score_q, last_score_d;
    logic [c_bcd_w-1:0]   bcd_q, bcd_d;
    logic [c_bcd_w-1:0]   digits_q, digits_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic [2:0]           lives_led_q, lives_led_d;
    logic [c_blk_w-1:0]   blink_cnt_q, blink_cnt_d;
    logic                 blink_hidden_q, blink_hidden_d;
    logic [c_bcd_w-1:0]   w_adj;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            shreg_q        <= '0;
            last_score_q   <= '0;
            bcd_q          <= '0;
            digits_q       <= '0;
            cnt_q          <= '0;
            busy_q         <= 1'b0;
            lives_led_q    <= 3'b000;
            blink_cnt_q    <= '0;
            blink_hidden_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            shreg_q        <= shreg_d;
            last_score_q   <= last_score_d;
            bcd_q          <= bcd_d;
            digits_q       <= digits_d;
            cnt_q          <= cnt_d;
            busy_q         <= busy_d;
            lives_led_q    <= lives_led_d;
            blink_cnt_q    <= blink_cnt_d;
            blink_hidden_q <= blink_hidden_d;
        end
    end

    // Double-dabble correction: any nibble >= 5 would overflow past 9 after the shift
    always_comb begin
        w_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        last_score_d = last_score_q;
        bcd_d        = bcd_q;
        digits_d     = digits_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        case (state_q)
            S_IDLE: begin
                if (score != last_score_q) begin
                    shreg_d      = score;
                    last_score_d = score;
                    bcd_d        = '0;
                    cnt_d        = c_cnt_w'(SCORE_W);
                    busy_d       = 1'b1;
                    state_d      = S_SHIFT;
                end
            end
            S_SHIFT: begin
                {bcd_d, shreg_d} = {w_adj[c_bcd_w-2:0], shreg_q, 1'b0};
                cnt_d            = cnt_q - c_cnt_w'(1);
                if (cnt_q == c_cnt_w'(1)) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                digits_d = bcd_q;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        case (lives)
            2'd3:    lives_led_d = 3'b111;
            2'd2:    lives_led_d = 3'b011;
            2'd1:    lives_led_d = 3'b001;
            default: lives_led_d = 3'b000;
        endcase
    end

    always_comb begin
        blink_cnt_d    = blink_cnt_q;
        blink_hidden_d = blink_hidden_q;
        if (!game_over) begin
            blink_cnt_d    = '0;
            blink_hidden_d = 1'b0;
        end else if (frame_tick) begin
            if (blink_cnt_q == c_blk_w'(BLINK_TICKS - 1)) begin
                blink_cnt_d    = '0;
                blink_hidden_d = ~blink_hidden_q;
            end else begin
                blink_cnt_d = blink_cnt_q + c_blk_w'(1);
            end
        end
    end

    logic [6:0] w_hex [DIGITS];

    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_digit
            if (k == 0) begin : g_lsd
                assign w_hex[k] = blink_hidden_q ? 7'h7F : seg7(digits_q[3:0]);
            end else begin : g_upper
                // A digit is a leading zero when it and everything above it is zero
                logic w_lead_zero;
                assign w_lead_zero = (digits_q[c_bcd_w-1:4*k] == '0);
                assign w_hex[k] = (blink_hidden_q || w_lead_zero) ? 7'h7F
                                                                  : seg7(digits_q[4*k +: 4]);
            end
        end
    endgenerate

    assign hex0      = w_hex[0];
    assign hex1      = w_hex[1];
    assign hex2      = w_hex[2];
    assign hex3      = w_hex[3];
    assign hex4      = w_hex[4];
    assign lives_led = lives_led_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_score_display.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_score_display
//  Description : Self-checking bench for score_display against a value-level
//                reference model (decimal arithmetic, conversion timer).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_score_display;

    localparam int SCORE_W     = 16;
    localparam int BLINK_TICKS = 30;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b0;
    logic        frame_tick = 1'b0;
    logic        game_over  = 1'b0;
    logic [15:0] score      = 16'd0;
    logic [1:0]  lives      = 2'd3;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4;
    logic [2:0]  lives_led;
    logic        busy;

    score_display #(
        .SCORE_W    (SCORE_W),
        .DIGITS     (5),
        .BLINK_TICKS(BLINK_TICKS)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .frame_tick(frame_tick),
        .score     (score),
        .lives     (lives),
        .game_over (game_over),
        .hex0      (hex0),
        .hex1      (hex1),
        .hex2      (hex2),
        .hex3      (hex3),
        .hex4      (hex4),
        .lives_led (lives_led),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: value last accepted, value on display, busy countdown
    logic [15:0] m_last   = 16'd0;
    logic [15:0] m_conv   = 16'd0;
    logic [15:0] m_disp   = 16'd0;
    int          m_timer  = 0;
    int          m_ticks  = 0;
    logic        m_hidden = 1'b0;
    logic [2:0]  m_led    = 3'b000;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_last   <= 16'd0;
            m_conv   <= 16'd0;
            m_disp   <= 16'd0;
            m_timer  <= 0;
            m_ticks  <= 0;
            m_hidden <= 1'b0;
            m_led    <= 3'b000;
        end else begin
            if (m_timer == 0) begin
                if (score != m_last) begin
                    m_last  <= score;
                    m_conv  <= score;
                    m_timer <= SCORE_W + 1;
                end
            end else begin
                m_timer <= m_timer - 1;
                if (m_timer == 1) m_disp <= m_conv;
            end
            m_led <= (lives == 2'd3) ? 3'b111 : (lives == 2'd2) ? 3'b011 :
                     (lives == 2'd1) ? 3'b001 : 3'b000;
            if (!game_over) begin
                m_ticks  <= 0;
                m_hidden <= 1'b0;
            end else if (frame_tick) begin
                if (m_ticks == BLINK_TICKS - 1) begin
                    m_ticks  <= 0;
                    m_hidden <= !m_hidden;
                end else begin
                    m_ticks <= m_ticks + 1;
                end
            end
        end
    end

    logic [6:0] seg_tab [10];
    initial begin
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    end

    function automatic logic [6:0] exp_hex(input int k);
        int v;
        int p;
        v = int'(m_disp);
        p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        if (m_hidden) return 7'h7F;
        if (k > 0 && v < p) return 7'h7F;
        return seg_tab[(v / p) % 10];
    endfunction

    always @(negedge clk) begin
        check_eq("hex0", 32'(hex0), 32'(exp_hex(0)));
        check_eq("hex1", 32'(hex1), 32'(exp_hex(1)));
        check_eq("hex2", 32'(hex2), 32'(exp_hex(2)));
        check_eq("hex3", 32'(hex3), 32'(exp_hex(3)));
        check_eq("hex4", 32'(hex4), 32'(exp_hex(4)));
        check_eq("busy", 32'(busy), 32'(m_timer != 0));
        check_eq("lives_led", 32'(lives_led), 32'(m_led));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int nb;
        // Reset and idle state
        step(3);
        check_eq("rst_hex0", 32'(hex0), 32'(7'b1000000));
        check_eq("rst_hex4", 32'(hex4), 32'(7'h7F));
        check_eq("rst_led", 32'(lives_led), 32'(3'b000));
        reset_n = 1'b1;
        step(1);
        check_eq("led_after_rst", 32'(lives_led), 32'(3'b111));
        step(5);
        check_eq("idle_busy", 32'(busy), 32'd0);

        // 0 -> 1234 latency
        score = 16'd1234;
        nb = 0;
        for (int c = 1; c <= 18; c++) begin
            step(1);
            if (busy) nb++;
            if (c == 17) check_eq("1234_early_hex0", 32'(hex0), 32'(7'b1000000));
        end
        check_eq("1234_busy_cycles", 32'(nb), 32'd17);
        check_eq("1234_hex3", 32'(hex3), 32'(7'b1111001));
        check_eq("1234_hex2", 32'(hex2), 32'(7'b0100100));
        check_eq("1234_hex1", 32'(hex1), 32'(7'b0110000));
        check_eq("1234_hex0", 32'(hex0), 32'(7'b0011001));
        check_eq("1234_hex4", 32'(hex4), 32'(7'h7F));

        // Maximum value, then shorter value clears upper digits
        score = 16'd65535;
        step(20);
        check_eq("max_hex4", 32'(hex4), 32'(7'b0000010));
        check_eq("max_hex3", 32'(hex3), 32'(7'b0010010));
        check_eq("max_hex2", 32'(hex2), 32'(7'b0010010));
        check_eq("max_hex1", 32'(hex1), 32'(7'b0110000));
        check_eq("max_hex0", 32'(hex0), 32'(7'b0010010));
        score = 16'd100;
        step(20);
        check_eq("100_hex4", 32'(hex4), 32'(7'h7F));
        check_eq("100_hex3", 32'(hex3), 32'(7'h7F));
        check_eq("100_hex2", 32'(hex2), 32'(7'b1111001));
        check_eq("100_hex1", 32'(hex1), 32'(7'b1000000));
        check_eq("100_hex0", 32'(hex0), 32'(7'b1000000));

        // Changes while busy: only the latest value is shown
        score = 16'd5000;
        step(3);
        score = 16'd7;
        step(1);
        score = 16'd8;
        step(1);
        score = 16'd9;
        step(36);
        check_eq("789_hex0", 32'(hex0), 32'(7'b0010000));
        check_eq("789_hex1", 32'(hex1), 32'(7'h7F));
        check_eq("789_hex3", 32'(hex3), 32'(7'h7F));
        check_eq("789_busy", 32'(busy), 32'd0);

        // Game-over blink, tick every 4 cycles
        score = 16'd42;
        step(20);
        game_over = 1'b1;
        for (int t = 0; t < 90; t++) begin
            frame_tick = 1'b1;
            step(1);
            frame_tick = 1'b0;
            step(3);
            if (t == 28) check_eq("blink_vis1", 32'(hex0), 32'(7'b0100100));
            if (t == 29) check_eq("blink_hid1", 32'(hex0), 32'(7'h7F));
            if (t == 58) check_eq("blink_hid2", 32'(hex1), 32'(7'h7F));
            if (t == 59) check_eq("blink_vis2", 32'(hex1), 32'(7'b0011001));
            if (t == 89) check_eq("blink_hid3", 32'(hex0), 32'(7'h7F));
        end
        game_over = 1'b0;
        step(1);
        check_eq("blink_drop", 32'(hex0), 32'(7'b0100100));

        // Lives thermometer
        lives = 2'd3; step(1); check_eq("lives3", 32'(lives_led), 32'(3'b111));
        lives = 2'd2; step(1); check_eq("lives2", 32'(lives_led), 32'(3'b011));
        lives = 2'd1; step(1); check_eq("lives1", 32'(lives_led), 32'(3'b001));
        lives = 2'd0; step(1); check_eq("lives0", 32'(lives_led), 32'(3'b000));

        // Asynchronous reset mid-conversion
        lives = 2'd2;
        score = 16'd4321;
        step(5);
        check_eq("pre_rst_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_hex0", 32'(hex0), 32'(7'b1000000));
        check_eq("mid_rst_hex1", 32'(hex1), 32'(7'h7F));
        check_eq("mid_rst_led", 32'(lives_led), 32'(3'b000));
        step(2);
        reset_n = 1'b1;
        step(19);
        check_eq("post_rst_hex3", 32'(hex3), 32'(7'b0011001));
        check_eq("post_rst_hex2", 32'(hex2), 32'(7'b0110000));
        check_eq("post_rst_hex1", 32'(hex1), 32'(7'b0100100));
        check_eq("post_rst_hex0", 32'(hex0), 32'(7'b1111001));
        check_eq("post_rst_hex4", 32'(hex4), 32'(7'h7F));

        // Randomized traffic, checked every cycle by the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 2))
                    0:       score = 16'($urandom);
                    1:       score = 16'($urandom_range(0, 99));
                    default: score = 16'($urandom_range(0, 9999));
                endcase
            end
            if ($urandom_range(0, 49) == 0) lives = 2'($urandom);
            if ($urandom_range(0, 299) == 0) game_over = !game_over;
            frame_tick = ($urandom_range(0, 3) == 0);
            step(1);
        end
        frame_tick = 1'b0;
        game_over  = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
